// File: rtl/dmem_initiator.sv
// dmem_initiator: load/store initiator between the core memory stage and a
// word-organised data memory. Issues word-aligned read/write beats with byte
// masks, splits word-crossing accesses into two beats, and reassembles and
// extends load data into a single response.
// Optional feature macro: DMEM_INIT_SPLIT_EN. When it is defined, crossing
// accesses are split into two beats. When it is undefined, a crossing access
// returns an error response and no beat is issued.
module dmem_initiator #(
    parameter int addrWidth = 32,
    parameter int dataWidth = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 reqValid,
    output logic                 reqReady,
    input  logic                 reqWe,
    input  logic [2:0]           reqOp,
    input  logic [addrWidth-1:0] reqAddr,
    input  logic [dataWidth-1:0] reqWdata,
    output logic                 respValid,
    output logic [dataWidth-1:0] respData,
    output logic                 respErr,
    output logic [addrWidth-1:0] memAddr,
    output logic                 memRe,
    output logic                 memWe,
    output logic [3:0]           memWmask,
    output logic [dataWidth-1:0] memWdata,
    input  logic [dataWidth-1:0] memRdata
);

`ifdef DMEM_INIT_SPLIT_EN
    localparam bit SplitEn = 1'b1;
`else
    localparam bit SplitEn = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, BEAT0, BEAT1, WAIT, RESP} state_t;

    state_t state_q, state_d;

    // registered outputs
    logic                 reqReady_q,  reqReady_d;
    logic                 respValid_q, respValid_d;
    logic [dataWidth-1:0] respData_q,  respData_d;
    logic                 respErr_q,   respErr_d;
    logic [addrWidth-1:0] memAddr_q,   memAddr_d;
    logic                 memRe_q,     memRe_d;
    logic                 memWe_q,     memWe_d;
    logic [3:0]           memWmask_q,  memWmask_d;
    logic [dataWidth-1:0] memWdata_q,  memWdata_d;

    // latched request context
    logic                 we_q;
    logic [2:0]           op_q;
    logic [1:0]           off_q;
    logic                 cross_q;
    logic [addrWidth-1:0] addr1_q;
    logic [3:0]           mask1_q;
    logic [dataWidth-1:0] wdata1_q;
    logic [dataWidth-1:0] rd0_q;

    // request decode
    logic                   accept;
    logic [2:0]             size_in;
    logic                   legal_in;
    logic [1:0]             off_in;
    logic                   cross_in;
    logic                   reject_in;
    logic [7:0]             mask_base;
    logic [7:0]             mask_wide;
    logic [2*dataWidth-1:0] wdata_wide;
    logic [addrWidth-1:0]   addr0_in;

    // load assembly
    logic [dataWidth-1:0] rd_lo, rd_hi, rd_sel, load_res;

    assign accept   = reqValid && reqReady_q;
    assign off_in   = reqAddr[1:0];
    assign addr0_in = {reqAddr[addrWidth-1:2], 2'b00};

    // op -> access size and legality; sized stores only for signed ops
    always_comb begin
        size_in  = 3'd0;
        legal_in = 1'b0;
        case (reqOp)
            3'd0: begin size_in = 3'd1; legal_in = 1'b1;   end
            3'd1: begin size_in = 3'd2; legal_in = 1'b1;   end
            3'd2: begin size_in = 3'd4; legal_in = 1'b1;   end
            3'd4: begin size_in = 3'd1; legal_in = !reqWe; end
            3'd5: begin size_in = 3'd2; legal_in = !reqWe; end
            default: ;
        endcase
    end

    // byte mask and data shifted across a two-word window; the upper half
    // is what spills into the second beat of a crossing access
    always_comb begin
        case (size_in)
            3'd1:    mask_base = 8'h01;
            3'd2:    mask_base = 8'h03;
            3'd4:    mask_base = 8'h0F;
            default: mask_base = 8'h00;
        endcase
        mask_wide  = mask_base << off_in;
        wdata_wide = {{dataWidth{1'b0}}, reqWdata} << {off_in, 3'b000};
        cross_in   = legal_in && (({1'b0, off_in} + size_in) > 3'd4);
        reject_in  = !legal_in || (cross_in && !SplitEn);
    end

    // reassemble {rd1,rd0}, align to the access offset, then extend
    always_comb begin
        rd_lo  = cross_q ? rd0_q : memRdata;
        rd_hi  = cross_q ? memRdata : '0;
        rd_sel = dataWidth'({rd_hi, rd_lo} >> {off_q, 3'b000});
        case (op_q)
            3'd0:    load_res = {{(dataWidth-8){rd_sel[7]}}, rd_sel[7:0]};
            3'd1:    load_res = {{(dataWidth-16){rd_sel[15]}}, rd_sel[15:0]};
            3'd4:    load_res = {{(dataWidth-8){1'b0}}, rd_sel[7:0]};
            3'd5:    load_res = {{(dataWidth-16){1'b0}}, rd_sel[15:0]};
            default: load_res = rd_sel;
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = reject_in ? RESP : BEAT0;
            BEAT0:   if (cross_q && SplitEn) state_d = BEAT1;
                     else                    state_d = we_q ? RESP : WAIT;
            BEAT1:   state_d = we_q ? RESP : WAIT;
            WAIT:    state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM output logic: next value of every registered output
    always_comb begin
        reqReady_d  = 1'b0;
        respValid_d = 1'b0;
        respData_d  = '0;
        respErr_d   = 1'b0;
        memAddr_d   = '0;
        memRe_d     = 1'b0;
        memWe_d     = 1'b0;
        memWmask_d  = 4'h0;
        memWdata_d  = '0;
        case (state_q)
            IDLE: begin
                if (!accept) begin
                    reqReady_d = 1'b1;
                end else if (reject_in) begin
                    respValid_d = 1'b1;
                    respErr_d   = 1'b1;
                end else begin
                    memAddr_d = addr0_in;
                    memRe_d   = !reqWe;
                    memWe_d   = reqWe;
                    if (reqWe) begin
                        memWmask_d = mask_wide[3:0];
                        memWdata_d = wdata_wide[dataWidth-1:0];
                    end
                end
            end
            BEAT0: begin
                if (cross_q && SplitEn) begin
                    memAddr_d = addr1_q;
                    memRe_d   = !we_q;
                    memWe_d   = we_q;
                    if (we_q) begin
                        memWmask_d = mask1_q;
                        memWdata_d = wdata1_q;
                    end
                end else if (we_q) begin
                    respValid_d = 1'b1;
                end
            end
            BEAT1: respValid_d = we_q;
            WAIT: begin
                respValid_d = 1'b1;
                respData_d  = load_res;
            end
            RESP: reqReady_d = 1'b1;
            default: ;
        endcase
    end

    // output registers; async reset drops every output, including a read beat
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            reqReady_q  <= 1'b0;
            respValid_q <= 1'b0;
            respData_q  <= '0;
            respErr_q   <= 1'b0;
            memAddr_q   <= '0;
            memRe_q     <= 1'b0;
            memWe_q     <= 1'b0;
            memWmask_q  <= 4'h0;
            memWdata_q  <= '0;
        end else begin
            reqReady_q  <= reqReady_d;
            respValid_q <= respValid_d;
            respData_q  <= respData_d;
            respErr_q   <= respErr_d;
            memAddr_q   <= memAddr_d;
            memRe_q     <= memRe_d;
            memWe_q     <= memWe_d;
            memWmask_q  <= memWmask_d;
            memWdata_q  <= memWdata_d;
        end
    end

    // request context latched on accept; first read beat captured in BEAT1
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            we_q     <= 1'b0;
            op_q     <= 3'd0;
            off_q    <= 2'd0;
            cross_q  <= 1'b0;
            addr1_q  <= '0;
            mask1_q  <= 4'h0;
            wdata1_q <= '0;
            rd0_q    <= '0;
        end else begin
            if (state_q == IDLE && accept) begin
                we_q     <= reqWe;
                op_q     <= reqOp;
                off_q    <= off_in;
                cross_q  <= cross_in;
                addr1_q  <= addr0_in + addrWidth'(4);
                mask1_q  <= mask_wide[7:4];
                wdata1_q <= wdata_wide[2*dataWidth-1:dataWidth];
            end
            if (state_q == BEAT1 && !we_q) rd0_q <= memRdata;
        end
    end

    assign reqReady  = reqReady_q;
    assign respValid = respValid_q;
    assign respData  = respData_q;
    assign respErr   = respErr_q;
    assign memAddr   = memAddr_q;
    assign memRe     = memRe_q;
    assign memWe     = memWe_q;
    assign memWmask  = memWmask_q;
    assign memWdata  = memWdata_q;

endmodule
